seg7_scan: RTL
==============

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter DIGITS, default 4, meaning number of multiplexed digits (legal 2..8).
REQ-002 Parameter SCAN_DIV, default 1, meaning clocks per PWM sub-phase (legal >=1); one digit slot is 16*SCAN_DIV clocks.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port digits_in, input, 4*DIGITS bits: digit k value at bits [4k+3:4k]; digit 0 is least significant and rightmost.
REQ-006 Port dp_in, input, DIGITS bits: decimal point request per digit.
REQ-007 Port blank_lz, input, 1 bit: enables leading-zero blanking.
REQ-008 Port brightness, input, 4 bits: display duty level 0..15.
REQ-009 Port seg, output, 7 bits, {g,f,e,d,c,b,a}, active-high.
REQ-010 Port seg_dp, output, 1 bit: decimal point segment h, active-high.
REQ-011 Port dig_en, output, DIGITS bits: one-hot-or-zero digit enable, active-high.

Function
REQ-012 Three counters SHALL cascade: pre 0..SCAN_DIV-1, pwm 0..15 (advances when pre wraps), slot 0..DIGITS-1 (advances when pwm wraps, wraps DIGITS-1 -> 0).
REQ-013 Frame start SHALL be the state pre=0, pwm=0, slot=0; on every rising edge where the counters are in that state, digits_in and dp_in SHALL be loaded into a snapshot register.
REQ-014 All decode SHALL use the snapshot only; input changes mid-frame SHALL NOT affect the display until the next frame.
REQ-015 seg, seg_dp and dig_en SHALL be registered, reflecting the counter/snapshot state one clock earlier (latency 1 clock).
REQ-016 dig_en SHALL have bit slot set only while pwm <= brightness, otherwise all zero; brightness 15 = full on, 0 = 1/16 duty.
REQ-017 brightness SHALL be sampled live each clock (no snapshot).
REQ-018 Decode 0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex, seg order of REQ-009).
REQ-019 Values 10..15: see REQ-026/027.
REQ-020 With blank_lz=1, digit k (k>=1) SHALL be blanked (seg=00) when the snapshot values of digit k and all higher digits are 0; digit 0 SHALL never be blanked; seg_dp SHALL follow dp_in of the digit regardless of blanking; dig_en is unaffected by blanking.
REQ-021 seg and seg_dp SHALL be forced to 0 whenever dig_en is all zero.

Reset
REQ-022 While rst_n=0: seg=0, seg_dp=0, dig_en=0, all counters 0, snapshot 0, asynchronously and regardless of clk.
REQ-023 The first frame after reset release SHALL display the zero snapshot; captured input data SHALL appear from the second frame.
REQ-024 Reset asserted mid-frame SHALL abort the scan immediately; after release, scanning restarts at slot 0.

Configuration
REQ-025 Macro SEG7_SCAN_HEX_EN selects the decode of values 10..15.
REQ-026 Defined: A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-027 Undefined: all of 10..15 SHALL decode to dash 40 (segment g only); leading-zero logic treats them as nonzero in both cases.

Verification (DIGITS=4, SCAN_DIV=1, slot = 16 clocks)
REQ-028 digits_in=16'h2563, brightness=15, blank_lz=0, second frame -> dig_en 0001/0010/0100/1000 for 16 clocks each, seg 4F,7D,6D,5B respectively.
REQ-029 digits_in=16'h0070, blank_lz=1 -> digits 3,2: seg 00; digit 1: 07; digit 0: 3F; with 16'h0000 only digit 0 shows 3F.
REQ-030 brightness=3 -> each dig_en bit high 4 consecutive clocks of its 16-clock slot, seg/seg_dp 0 the other 12.
REQ-031 digits_in changed 16'h2563 -> 16'h2564 during slot 2 -> digit 0 shows 4F until the next frame start, 66 thereafter.
REQ-032 rst_n pulled low mid-slot 2 -> all outputs 0 within the same cycle; after release, first 16 clocks enable dig_en=0001 with seg 3F.
REQ-033 digit 0 = 4'hB, dp_in=4'b0001 -> seg 7C, seg_dp 1 with SEG7_SCAN_HEX_EN; seg 40, seg_dp 1 without.

Source files
------------

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed 7-segment scanner with PWM dimming and leading-zero blanking
// Optional macro SEG7_SCAN_HEX_EN: decode values 10..15 as hex glyphs instead of a dash.
module seg7_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [3:0]            brightness,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     dig_en
);

  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0]         pre;
  logic [3:0]            pwm;
  logic [SW-1:0]         slot;
  logic                  pre_wrap;
  logic                  pwm_wrap;
  logic                  frame_start;
  logic                  started;
  logic                  load;
  logic [4*DIGITS-1:0]   snap_digits;
  logic [DIGITS-1:0]     snap_dp;
  logic [4*DIGITS-1:0]   snap_digits_d;
  logic [DIGITS-1:0]     snap_dp_d;
  logic [3:0]            cur;
  logic                  blank;
  logic                  lit;
  logic [6:0]            seg_d;
  logic                  seg_dp_d;
  logic [DIGITS-1:0]     dig_en_d;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0:    seg_of = 7'h3F;
      4'd1:    seg_of = 7'h06;
      4'd2:    seg_of = 7'h5B;
      4'd3:    seg_of = 7'h4F;
      4'd4:    seg_of = 7'h66;
      4'd5:    seg_of = 7'h6D;
      4'd6:    seg_of = 7'h7D;
      4'd7:    seg_of = 7'h07;
      4'd8:    seg_of = 7'h7F;
      4'd9:    seg_of = 7'h6F;
`ifdef SEG7_SCAN_HEX_EN
      4'd10:   seg_of = 7'h77;
      4'd11:   seg_of = 7'h7C;
      4'd12:   seg_of = 7'h39;
      4'd13:   seg_of = 7'h5E;
      4'd14:   seg_of = 7'h79;
      default: seg_of = 7'h71;
`else
      default: seg_of = 7'h40;
`endif
    endcase
  endfunction

  assign pre_wrap    = (pre == PW'(SCAN_DIV - 1));
  assign pwm_wrap    = pre_wrap && (pwm == 4'd15);
  assign frame_start = (pre == '0) && (pwm == 4'd0) && (slot == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre  <= '0;
      pwm  <= '0;
      slot <= '0;
    end else begin
      pre <= pre_wrap ? '0 : pre + PW'(1);
      if (pre_wrap) pwm <= pwm + 4'd1;
      if (pwm_wrap) slot <= (slot == SW'(DIGITS - 1)) ? '0 : slot + SW'(1);
    end
  end

  // The frame that begins at reset release shows the cleared snapshot, so the
  // very first frame-start edge after reset does not capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) started <= 1'b0;
    else        started <= 1'b1;
  end

  assign load = frame_start && started;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_digits <= '0;
      snap_dp     <= '0;
    end else if (load) begin
      snap_digits <= digits_in;
      snap_dp     <= dp_in;
    end
  end

  // Decode from the value the snapshot holds for this frame, including the
  // capture edge itself, so a whole displayed frame comes from one snapshot.
  assign snap_digits_d = load ? digits_in : snap_digits;
  assign snap_dp_d     = load ? dp_in : snap_dp;

  always_comb begin
    cur      = snap_digits_d[4*int'(slot) +: 4];
    lit      = (pwm <= brightness);
    blank    = blank_lz && (slot != '0) && ((snap_digits_d >> (4*int'(slot))) == '0);
    seg_d    = 7'h00;
    seg_dp_d = 1'b0;
    dig_en_d = '0;
    if (lit) begin
      dig_en_d = DIGITS'(1) << slot;
      seg_d    = blank ? 7'h00 : seg_of(cur);
      seg_dp_d = snap_dp_d[slot];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg    <= '0;
      seg_dp <= 1'b0;
      dig_en <= '0;
    end else begin
      seg    <= seg_d;
      seg_dp <= seg_dp_d;
      dig_en <= dig_en_d;
    end
  end

endmodule
